// File: rtl/cc_bus_ctrl.sv
// ---------------------------------------------------------------------------
// cc_bus_ctrl -- two-cache snooping coherence bus controller with a single
// shared RAM port. Cache blocks are two 32-bit words; daddr[2] picks the word.
//
// Arbitrates coherence requests (cctrans) between two caches. It broadcasts
// the snoop address, an optional invalidate and a snoop-busy flag to the
// other cache. It then either:
//   - finishes straight away (upgrade),
//   - takes the block from a dirty snooper, or
//   - fills the requester from RAM.
// While no coherence traffic is pending, eviction/flush writes (dWEN without
// cctrans) are passed straight through to RAM.
//
// Build option: define CC_SNOOP_FWD_EN to forward dirty snoop data directly
// cache-to-cache while it is written back to RAM. When it is undefined, dirty
// data is first written back to RAM and the requester is then filled from
// RAM.
//
// Ports
//   CLK, RST        clock; asynchronous active-high reset
//   cctrans[1:0]    per-cache coherence request
//   ccwrite[1:0]    requester: upgrade (invalidate) request;
//                   snooper: holds dirty copy
//   dREN/dWEN[1:0]  per-cache data read / write strobes
//   daddr/dstore    per-cache word address / store data (2 x 32)
//   dwait[1:0]      per-cache stall
//   dload           per-cache load data (2 x 32)
//   ccwait[1:0]     snoop in progress (to the snooped cache)
//   ccinv[1:0]      invalidate (to the snooped cache)
//   ccsnoopaddr     snoop address (2 x 32)
//   ramREN/ramWEN   RAM read / write strobes
//   ramaddr         RAM address
//   ramstore        RAM write data
//   ramload         RAM read data
//   ramwait         RAM busy
// ---------------------------------------------------------------------------
module cc_bus_ctrl (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       cctrans,
  input  logic [1:0]       ccwrite,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] dload,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic             ramwait
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ARB   = 4'd1,
    SNOOP = 4'd2,
    FWD0  = 4'd3,
    FWD1  = 4'd4,
    LD0   = 4'd5,
    LD1   = 4'd6,
    WB    = 4'd7,
    DONE  = 4'd8
  } state_t;

  state_t           state_r, state_s;
  logic [1:0]       pend_r, pend_s;     // requests captured when leaving IDLE
  logic             req_r, req_s;       // granted requester
  logic [31:0]      addr_r, addr_s;     // requester's address at grant
  logic             inv_r, inv_s;       // upgrade (invalidate) transaction
  logic             last_r, last_s;     // cache granted most recently
  logic             owner_r, owner_s;   // cache owning a pass-through writeback
  logic             grant_s;
  logic             in_snoop_s;

  logic [1:0]       ccwait_r, ccinv_r;
  logic [1:0][31:0] snaddr_r;
  logic             ramren_r;

  // Next state and transaction context.
  // Requests are captured into pend_r, so a cctrans dropped after IDLE
  // cannot abort the transaction.
  always_comb begin
    state_s = state_r;
    pend_s  = pend_r;
    req_s   = req_r;
    addr_s  = addr_r;
    inv_s   = inv_r;
    last_s  = last_r;
    owner_s = owner_r;
    grant_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cctrans != 2'b00) begin
          state_s = ARB;
          pend_s  = cctrans;
        end else if (dWEN[0]) begin
          state_s = WB;
          owner_s = 1'b0;
        end else if (dWEN[1]) begin
          state_s = WB;
          owner_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ARB: begin
        // On a tie, the cache that did not win last time gets the bus.
        if (pend_r == 2'b11) begin
          grant_s = ~last_r;
        end else if (pend_r[1]) begin
          grant_s = 1'b1;
        end else begin
          grant_s = 1'b0;
        end
        req_s   = grant_s;
        addr_s  = daddr[grant_s];
        inv_s   = ccwrite[grant_s];
        last_s  = grant_s;
        state_s = SNOOP;
      end
      SNOOP: begin
        if (inv_r) begin
          state_s = DONE;
        end else if (ccwrite[~req_r]) begin
          state_s = FWD0;
        end else begin
          state_s = LD0;
        end
      end
      FWD0: begin
        if (!ramwait) begin
          state_s = FWD1;
        end else begin
          state_s = FWD0;
        end
      end
      FWD1: begin
        if (!ramwait) begin
`ifdef CC_SNOOP_FWD_EN
          state_s = DONE;
`else
          state_s = LD0;
`endif
        end else begin
          state_s = FWD1;
        end
      end
      LD0: begin
        if (!ramwait) begin
          state_s = LD1;
        end else begin
          state_s = LD0;
        end
      end
      LD1: begin
        if (!ramwait) begin
          state_s = DONE;
        end else begin
          state_s = LD1;
        end
      end
      WB: begin
        if (!dWEN[owner_r]) begin
          state_s = IDLE;
        end else begin
          state_s = WB;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Snoop phase as seen from the upcoming state, so snoop outputs can be
  // registered.
  assign in_snoop_s = (state_s == SNOOP) || (state_s == FWD0) ||
                      (state_s == FWD1)  || (state_s == LD0)  ||
                      (state_s == LD1);

  // FSM state, transaction context and registered snoop/read-strobe outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r  <= IDLE;
      pend_r   <= 2'b00;
      req_r    <= 1'b0;
      addr_r   <= 32'h0000_0000;
      inv_r    <= 1'b0;
      last_r   <= 1'b1;
      owner_r  <= 1'b0;
      ccwait_r <= 2'b00;
      ccinv_r  <= 2'b00;
      snaddr_r <= '0;
      ramren_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      pend_r   <= pend_s;
      req_r    <= req_s;
      addr_r   <= addr_s;
      inv_r    <= inv_s;
      last_r   <= last_s;
      owner_r  <= owner_s;
      ccwait_r <= 2'b00;
      ccinv_r  <= 2'b00;
      snaddr_r <= '0;
      if (in_snoop_s) begin
        ccwait_r[~req_s] <= 1'b1;
        ccinv_r[~req_s]  <= inv_s;
        snaddr_r[~req_s] <= addr_s;
      end
      ramren_r <= (state_s == LD0) || (state_s == LD1);
    end
  end

  // RAM write port, load data and stalls.
  // These follow ramwait/dstore within the same cycle so the RAM handshake
  // adds no latency.
  always_comb begin
    dwait    = 2'b11;
    dload    = '0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    ramWEN   = 1'b0;
    case (state_r)
      FWD0, FWD1: begin
        // Snooper drives its dirty words; both are written back to RAM.
        ramWEN   = 1'b1;
        ramaddr  = daddr[~req_r];
        ramstore = dstore[~req_r];
`ifdef CC_SNOOP_FWD_EN
        dload[req_r] = dstore[~req_r];
        dwait        = {ramwait, ramwait};
`else
        dwait[~req_r] = ramwait;
`endif
      end
      LD0, LD1: begin
        ramaddr       = {addr_r[31:3], (state_r == LD1), 2'b00};
        dload[req_r]  = ramload;
        // A fill is only released to a cache that is actually reading.
        dwait[req_r]  = ramwait | ~dREN[req_r];
      end
      WB: begin
        ramWEN          = dWEN[owner_r];
        ramaddr         = daddr[owner_r];
        ramstore        = dstore[owner_r];
        dwait[owner_r]  = ramwait;
      end
      default: begin
        dwait = 2'b11;
      end
    endcase
  end

  assign ccwait      = ccwait_r;
  assign ccinv       = ccinv_r;
  assign ccsnoopaddr = snaddr_r;
  assign ramREN      = ramren_r;

endmodule

// File: tb/tb_cc_bus_ctrl.sv
// Self-checking bench for cc_bus_ctrl: transaction-level expectations
// (which RAM writes/reads occur, which words the requester receives) built
// from the protocol rules, compared with what is observed on the ports.
module tb_cc_bus_ctrl;

`ifdef CC_SNOOP_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST;
  logic [1:0]       cctrans, ccwrite, dREN, dWEN;
  logic [1:0][31:0] daddr, dstore, dload, ccsnoopaddr;
  logic [1:0]       dwait, ccwait, ccinv;
  logic             ramREN, ramWEN, ramwait;
  logic [31:0]      ramaddr, ramstore, ramload;

  int checks = 0;
  int errors = 0;
  int exp_last;
  logic [31:0] wr_a[$], wr_d[$], rd_a[$], rx_d[$];

  always #5 CLK = ~CLK;

  cc_bus_ctrl dut (
    .CLK(CLK), .RST(RST), .cctrans(cctrans), .ccwrite(ccwrite),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramwait(ramwait)
  );

  // RAM contents as a function of address
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {16'hAAAA, a[15:0]};
  endfunction

  // Pack a short queue as {size, q[0], q[1]} for printing/comparing
  function automatic logic [67:0] pk(input logic [31:0] q[$]);
    logic [67:0] v;
    v = '0;
    v[67:64] = (q.size() > 15) ? 4'd15 : 4'(q.size());
    if (q.size() > 0) v[63:32] = q[0];
    if (q.size() > 1) v[31:0] = q[1];
    return v;
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    cctrans = 2'b11; ccwrite = 2'b00; dREN = 2'b00; dWEN = 2'b11;
    daddr[0] = 32'h1234_5678; daddr[1] = 32'h8765_4321;
    dstore[0] = 32'hDEAD_BEEF; dstore[1] = 32'hCAFE_F00D;
    ramwait = 1'b0; ramload = 32'h0;
    @(negedge CLK); @(negedge CLK); #2;
    checks++; if (dwait !== 2'b11) begin errors++; $display("FAIL reset_dwait: got %b want 11", dwait); end
    checks++; if (ccwait !== 2'b00 || ccinv !== 2'b00) begin errors++; $display("FAIL reset_cc: got ccwait=%b ccinv=%b want 00/00", ccwait, ccinv); end
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL reset_ram: got ren=%b wen=%b want 0/0", ramREN, ramWEN); end
    checks++; if ({ramaddr, ramstore, dload, ccsnoopaddr} !== '0) begin errors++; $display("FAIL reset_data: got addr=%h store=%h dload=%h snoop=%h want 0", ramaddr, ramstore, dload, ccsnoopaddr); end
    cctrans = 2'b00; dWEN = 2'b00;
    @(negedge CLK); RST = 1'b0;
    exp_last = 1;
  endtask

  // Generic coherence transaction from requester r with a behavioural snooper and RAM
  task automatic run_txn(input int r, input bit upg, input bit dirty, input logic [31:0] a,
                         input logic [31:0] w0, input logic [31:0] w1, input int stall_pct,
                         input int burst_in, input string nm);
    int o, sn, hold, n, viol, nwait, burst;
    bit seen, fin, done_ok;
    logic [31:0] ewa[$], ewd[$], era[$], erx[$];
    logic [31:0] b0, b1;
    o = 1 - r; sn = 0; n = 0; viol = 0; nwait = 0; burst = burst_in;
    hold = $urandom_range(1, 3);
    seen = 1'b0; fin = 1'b0; done_ok = 1'b0;
    wr_a.delete(); wr_d.delete(); rd_a.delete(); rx_d.delete();
    b0 = {a[31:3], 3'b000}; b1 = {a[31:3], 3'b100};
    if (upg) begin
      // upgrade: no data movement at all
    end else if (dirty) begin
      ewa.push_back(b0); ewa.push_back(b1); ewd.push_back(w0); ewd.push_back(w1);
      if (FWD) begin
        erx.push_back(w0); erx.push_back(w1);
      end else begin
        era.push_back(b0); era.push_back(b1);
        erx.push_back(mem_val(b0)); erx.push_back(mem_val(b1));
      end
    end else begin
      era.push_back(b0); era.push_back(b1);
      erx.push_back(mem_val(b0)); erx.push_back(mem_val(b1));
    end
    @(negedge CLK);
    cctrans = 2'b00; ccwrite = 2'b00; dREN = 2'b00; dWEN = 2'b00;
    cctrans[r] = 1'b1; ccwrite[r] = upg; ccwrite[o] = dirty; daddr[r] = a; dREN[r] = 1'b1;
    while (!fin && n < 80) begin
      if (n >= hold) cctrans[r] = 1'b0;
      if (seen && burst > 0) begin
        ramwait = 1'b1; burst--;
      end else begin
        ramwait = ($urandom_range(0, 99) < stall_pct);
      end
      daddr[o] = {a[31:3], sn[0], 2'b00};
      dstore[o] = (sn == 0) ? w0 : w1;
      #1 ramload = mem_val(ramaddr);
      #1;
      if (ramREN && ramWEN) viol |= 1;
      if (ccwait == 2'b11 || ccwait[r]) viol |= 2;
      if (ramwait && dwait !== 2'b11) viol |= 4;
      if (ccwait[o]) begin
        seen = 1'b1; nwait++;
        if (ccsnoopaddr[o] !== a || ccinv[o] !== upg) viol |= 8;
        if (ramWEN && !ramwait) begin wr_a.push_back(ramaddr); wr_d.push_back(ramstore); end
        if (ramREN && !ramwait) rd_a.push_back(ramaddr);
        if (!dwait[r]) rx_d.push_back(dload[r]);
        if (!dwait[o]) sn++;
      end else if (seen) begin
        fin = 1'b1;
        done_ok = (dwait === 2'b11) && !ramREN && !ramWEN && (ccinv === 2'b00);
      end
      @(negedge CLK); n++;
    end
    cctrans = 2'b00; ccwrite = 2'b00; dREN = 2'b00; ramwait = 1'b0;
    exp_last = r;
    checks++; if (!fin) begin errors++; $display("FAIL %s_complete: got no DONE within %0d cycles, want DONE", nm, n); end
    checks++; if (viol != 0) begin errors++; $display("FAIL %s_protocol: got violation mask %0d want 0", nm, viol); end
    checks++; if (!done_ok) begin errors++; $display("FAIL %s_done: got dwait=%b ren=%b wen=%b want 11/0/0", nm, dwait, ramREN, ramWEN); end
    checks++; if (pk(wr_a) !== pk(ewa) || pk(wr_d) !== pk(ewd)) begin errors++; $display("FAIL %s_writes: got a=%h d=%h want a=%h d=%h", nm, pk(wr_a), pk(wr_d), pk(ewa), pk(ewd)); end
    checks++; if (pk(rd_a) !== pk(era)) begin errors++; $display("FAIL %s_reads: got %h want %h", nm, pk(rd_a), pk(era)); end
    checks++; if (pk(rx_d) !== pk(erx)) begin errors++; $display("FAIL %s_rxdata: got %h want %h", nm, pk(rx_d), pk(erx)); end
    if (upg) begin
      checks++; if (nwait != 1) begin errors++; $display("FAIL %s_upg_len: got %0d snoop cycles want 1", nm, nwait); end
    end
  endtask

  task automatic test_arbitration();
    int g, n;
    logic [1:0] got, ginv, exp_m;
    for (int k = 0; k < 2; k++) begin
      g = 1 - exp_last; n = 0; got = 2'b00; ginv = 2'b00;
      exp_m = (g == 0) ? 2'b10 : 2'b01;
      @(negedge CLK);
      cctrans = 2'b11; ccwrite = 2'b11; ramwait = 1'b0;
      daddr[0] = $urandom; daddr[1] = $urandom;
      while (got == 2'b00 && n < 10) begin
        #2; got = ccwait; ginv = ccinv;
        @(negedge CLK); cctrans = 2'b00; n++;
      end
      checks++; if (got !== exp_m) begin errors++; $display("FAIL arb_grant%0d: got ccwait=%b want %b", k, got, exp_m); end
      checks++; if (ginv !== exp_m) begin errors++; $display("FAIL arb_inv%0d: got ccinv=%b want %b", k, ginv, exp_m); end
      exp_last = g;
      n = 0; #2;
      while (ccwait != 2'b00 && n < 10) begin @(negedge CLK); #2; n++; end
      ccwrite = 2'b00;
    end
  endtask

  task automatic test_writeback(input int own);
    int n, w, bad;
    bit fin;
    logic [31:0] a, d0, d1;
    logic [31:0] ea[$], ed[$];
    a = $urandom; d0 = $urandom; d1 = $urandom;
    n = 0; w = 0; bad = 0; fin = 1'b0;
    wr_a.delete(); wr_d.delete();
    ea.push_back({a[31:3], 3'b000}); ea.push_back({a[31:3], 3'b100});
    ed.push_back(d0); ed.push_back(d1);
    @(negedge CLK);
    cctrans = 2'b00; ccwrite = 2'b00; dREN = 2'b00;
    while (!fin && n < 60) begin
      dWEN = 2'b00; dWEN[own] = (w < 2);
      daddr[own] = {a[31:3], w[0], 2'b00};
      dstore[own] = (w == 0) ? d0 : d1;
      ramwait = ($urandom_range(0, 99) < 30);
      #2;
      if (ramREN || ccwait != 2'b00 || dwait[1-own] !== 1'b1) bad++;
      if (ramWEN && dwait[own] !== ramwait) bad++;
      if (ramWEN && !ramwait) begin wr_a.push_back(ramaddr); wr_d.push_back(ramstore); end
      if (w >= 2) fin = 1'b1;
      else if (ramWEN && !dwait[own]) w++;
      @(negedge CLK); n++;
    end
    ramwait = 1'b0; dWEN = 2'b00; #2;
    checks++; if (!fin) begin errors++; $display("FAIL wb%0d_complete: got %0d words want 2", own, w); end
    checks++; if (bad != 0) begin errors++; $display("FAIL wb%0d_protocol: got %0d bad cycles want 0", own, bad); end
    checks++; if (pk(wr_a) !== pk(ea) || pk(wr_d) !== pk(ed)) begin errors++; $display("FAIL wb%0d_writes: got a=%h d=%h want a=%h d=%h", own, pk(wr_a), pk(wr_d), pk(ea), pk(ed)); end
    checks++; if (ramWEN !== 1'b0 || dwait !== 2'b11) begin errors++; $display("FAIL wb%0d_idle: got wen=%b dwait=%b want 0/11", own, ramWEN, dwait); end
  endtask

  task automatic test_reset_mid_load();
    int r, n, reads, stray;
    bit hit;
    logic [31:0] a;
    r = $urandom_range(0, 1); a = $urandom;
    n = 0; reads = 0; hit = 1'b0; stray = 0;
    @(negedge CLK);
    cctrans = 2'b00; cctrans[r] = 1'b1; ccwrite = 2'b00; dWEN = 2'b00;
    dREN = 2'b00; dREN[r] = 1'b1; daddr[r] = a;
    while (!hit && n < 40) begin
      ramwait = (reads >= 1);
      #1 ramload = mem_val(ramaddr);
      #1;
      if (ramREN && !ramwait) reads++;
      else if (ramREN && reads == 1) hit = 1'b1;
      if (!hit) begin @(negedge CLK); cctrans = 2'b00; n++; end
    end
    checks++; if (!hit || ramaddr !== {a[31:3], 3'b100}) begin errors++; $display("FAIL rst_ld1_reach: got hit=%b addr=%h want 1/%h", hit, ramaddr, {a[31:3], 3'b100}); end
    RST = 1'b1; #1;
    checks++; if (dwait !== 2'b11 || ccwait !== 2'b00 || ccinv !== 2'b00 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got dwait=%b ccwait=%b ccinv=%b ren=%b wen=%b want 11/00/00/0/0", dwait, ccwait, ccinv, ramREN, ramWEN); end
    checks++; if ({ramaddr, dload, ccsnoopaddr} !== '0) begin errors++; $display("FAIL rst_mid_data: got addr=%h dload=%h snoop=%h want 0", ramaddr, dload, ccsnoopaddr); end
    @(negedge CLK);
    RST = 1'b0; cctrans = 2'b00; dREN = 2'b00; ramwait = 1'b0;
    exp_last = 1;
    for (int i = 0; i < 12; i++) begin
      #2; if (ramREN || ramWEN || ccwait != 2'b00) stray++;
      @(negedge CLK);
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rst_no_access: got %0d active cycles want 0", stray); end
  endtask

  task automatic test_random();
    int r;
    bit upg, dirty;
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 1);
      upg = ($urandom_range(0, 3) == 0);
      dirty = $urandom_range(0, 1);
      run_txn(r, upg, dirty, $urandom, $urandom, $urandom, 30, 0, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    run_txn(0, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 0, 0, "load0");
    run_txn(1, 1'b1, 1'b0, 32'h0000_1238, 32'h0, 32'h0, 0, 0, "upgrade1");
    run_txn(0, 1'b0, 1'b1, 32'h0000_4560, 32'h1234_5678, 32'h9ABC_DEF0, 0, 3, "dirty");
    test_writeback(1);
    test_writeback(0);
    test_reset_mid_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
